// File: rtl/moving_average_dual.sv
// rtl/moving_average_dual.sv - two-channel boxcar moving average with run-time window 2^L
//
// Purpose:
//   Averages each of two signed sample streams over the last 2^L samples, where
//   L = min(Control0[3:0], G_MAX_LENGTH_LOG). Optional round-half-up, hold/freeze,
//   and a Filled flag that marks outputs computed from a complete window.
//
// Ports:
//   Clk       clock, rising edge
//   Reset     synchronous, active-high
//   InputA/B  signed samples, G_DATA_WIDTH bits
//   Control0  [3:0] window log2 request, [4] round enable, [5] hold, rest ignored
//   Control1  reserved, ignored
//   OutputA/B signed averages, registered
//   Filled    high when OutputA/B come from a full window

module moving_average_dual #(
  parameter int G_DATA_WIDTH     = 16,
  parameter int G_MAX_LENGTH_LOG = 10
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic signed [G_DATA_WIDTH-1:0] InputA,
  input  logic signed [G_DATA_WIDTH-1:0] InputB,
  input  logic        [15:0]             Control0,
  input  logic        [15:0]             Control1,
  output logic signed [G_DATA_WIDTH-1:0] OutputA,
  output logic signed [G_DATA_WIDTH-1:0] OutputB,
  output logic                           Filled
);

  localparam int W     = G_DATA_WIDTH;
  localparam int M     = G_MAX_LENGTH_LOG;
  localparam int AW    = W + M;
  localparam int DEPTH = 1 << M;

  typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  run;

  logic [3:0]            l_eff;
  logic [3:0]            l_reg;
  logic                  round_en;
  logic                  hold;
  logic                  flush;
  logic                  accept;

  logic [M-1:0]          wr_ptr;
  logic [M-1:0]          rd_ptr;
  logic [M-1:0]          fill_cnt;
  logic [M:0]            win;
  logic                  fill_last;

  logic signed [W-1:0]   ram_a [DEPTH];
  logic signed [W-1:0]   ram_b [DEPTH];
  logic signed [W-1:0]   old_a;
  logic signed [W-1:0]   old_b;

  logic signed [AW-1:0]  acc_a;
  logic signed [AW-1:0]  acc_b;
  logic        [AW:0]    half;
  logic signed [AW:0]    sum_a;
  logic signed [AW:0]    sum_b;
  logic signed [W-1:0]   y_a;
  logic signed [W-1:0]   y_b;

  logic                  unused_ctrl;
  assign unused_ctrl = ^{Control1, Control0[15:6]};

  assign l_eff    = (Control0[3:0] > 4'(M)) ? 4'(M) : Control0[3:0];
  assign round_en = Control0[4];
  assign hold     = Control0[5];
  assign flush    = (l_eff != l_reg);
  assign accept   = !flush && !hold;

  // Window size as M+1 bits so that 2^M is representable; its low M bits are
  // zero at L=M, which makes the read pointer equal the write pointer and
  // fetches the sample written exactly 2^M accepts ago.
  assign win       = (M+1)'(1) << l_reg;
  assign rd_ptr    = wr_ptr - win[M-1:0];
  assign fill_last = ({1'b0, fill_cnt} == (win - (M+1)'(1)));

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_FILL;
    end else if (accept && (state == ST_FILL) && fill_last) begin
      state_nxt = ST_RUN;
    end
  end

  // State-decoded outputs: while filling nothing is subtracted, so RAM left
  // over from before a flush or reset never reaches the accumulators.
  always_comb begin
    run   = (state == ST_RUN);
    old_a = '0;
    old_b = '0;
    if (run) begin
      old_a = ram_a[rd_ptr];
      old_b = ram_b[rd_ptr];
    end
  end

  // Sample buffers, no reset so they map onto RAM
  always_ff @(posedge Clk) begin
    if (!Reset && accept) begin
      ram_a[wr_ptr] <= InputA;
      ram_b[wr_ptr] <= InputB;
    end
  end

  // Accumulators, pointer, fill counter and window register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_a    <= '0;
      acc_b    <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      l_reg    <= l_eff;
    end else if (flush) begin
      acc_a    <= '0;
      acc_b    <= '0;
      fill_cnt <= '0;
      l_reg    <= l_eff;
    end else if (accept) begin
      wr_ptr <= wr_ptr + M'(1);
      acc_a  <= acc_a + {{M{InputA[W-1]}}, InputA} - {{M{old_a[W-1]}}, old_a};
      acc_b  <= acc_b + {{M{InputB[W-1]}}, InputB} - {{M{old_b[W-1]}}, old_b};
      if (state == ST_FILL) begin
        fill_cnt <= fill_cnt + M'(1);
      end
    end
  end

  // Divide by 2^L with optional round-half-up; one extra bit keeps the
  // rounding add from wrapping at the positive extreme.
  assign half  = (round_en && (l_reg != 4'd0)) ? ((AW+1)'(1) << (l_reg - 4'd1)) : '0;
  assign sum_a = $signed({acc_a[AW-1], acc_a}) + $signed(half);
  assign sum_b = $signed({acc_b[AW-1], acc_b}) + $signed(half);
  assign y_a   = W'(sum_a >>> l_reg);
  assign y_b   = W'(sum_b >>> l_reg);

  // Output stage; a flush overrides hold so it still updates.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutputA <= '0;
      OutputB <= '0;
      Filled  <= 1'b0;
    end else if (flush || !hold) begin
      OutputA <= run ? y_a : '0;
      OutputB <= run ? y_b : '0;
      Filled  <= run;
    end
  end

endmodule

// File: tb/tb_moving_average_dual.sv
// tb/tb_moving_average_dual.sv - self-checking bench for moving_average_dual

module tb_moving_average_dual;

  logic               Clk;
  logic               Reset;
  logic signed [15:0] InputA;
  logic signed [15:0] InputB;
  logic        [15:0] Control0;
  logic        [15:0] Control1;
  logic signed [15:0] OutputA;
  logic signed [15:0] OutputB;
  logic               Filled;

  moving_average_dual #(
    .G_DATA_WIDTH     (16),
    .G_MAX_LENGTH_LOG (10)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .InputA   (InputA),
    .InputB   (InputB),
    .Control0 (Control0),
    .Control1 (Control1),
    .OutputA  (OutputA),
    .OutputB  (OutputB),
    .Filled   (Filled)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          rst;
    logic [15:0] ctrl;
    int          a;
    int          b;
    bit          chk;
    int          ea;
    int          eb;
    bit          ef;
  } vec_t;

  typedef struct {
    int a;
    int b;
    bit f;
  } exp_t;

  vec_t   vecs[$];
  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  // Reference model: keeps the raw sample history since the last flush and
  // sums the newest 2^L entries directly.
  int     m_l   = 0;
  bit     m_run = 0;
  int     m_cnt = 0;
  longint m_ha[$];
  longint m_hb[$];
  int     m_oa  = 0;
  int     m_ob  = 0;
  bit     m_of  = 0;

  function automatic void add(input bit rst, input int ctrl, input int a, input int b);
    vec_t v;
    v.rst = rst; v.ctrl = 16'(ctrl); v.a = a; v.b = b;
    v.chk = 1'b0; v.ea = 0; v.eb = 0; v.ef = 1'b0;
    vecs.push_back(v);
  endfunction

  function automatic void addc(input bit rst, input int ctrl, input int a, input int b,
                               input int ea, input int eb, input bit ef);
    vec_t v;
    v.rst = rst; v.ctrl = 16'(ctrl); v.a = a; v.b = b;
    v.chk = 1'b1; v.ea = ea; v.eb = eb; v.ef = ef;
    vecs.push_back(v);
  endfunction

  function automatic int avg(input bit ch, input int l, input bit rnd);
    longint s  = 0;
    int     n  = 1 << l;
    int     sz = ch ? m_hb.size() : m_ha.size();
    for (int k = sz - n; k < sz; k++) begin
      s += ch ? m_hb[k] : m_ha[k];
    end
    if (rnd && l > 0) s += longint'(1) << (l - 1);
    return int'(s >>> l);
  endfunction

  task automatic model_step(input bit rst, input logic [15:0] c, input int a, input int b);
    int   leff;
    bit   hld;
    bit   rnd;
    bit   fl;
    exp_t e;
    leff = (c[3:0] > 4'd10) ? 10 : int'(c[3:0]);
    hld  = c[5];
    rnd  = c[4];
    if (rst) begin
      m_ha.delete(); m_hb.delete();
      m_cnt = 0; m_run = 0; m_l = leff;
      m_oa = 0; m_ob = 0; m_of = 0;
    end else begin
      fl = (leff != m_l);
      if (fl || !hld) begin
        m_oa = m_run ? avg(1'b0, m_l, rnd) : 0;
        m_ob = m_run ? avg(1'b1, m_l, rnd) : 0;
        m_of = m_run;
      end
      if (fl) begin
        m_ha.delete(); m_hb.delete();
        m_cnt = 0; m_run = 0; m_l = leff;
      end else if (!hld) begin
        m_ha.push_back(longint'(a));
        m_hb.push_back(longint'(b));
        if (m_ha.size() > 1024) begin
          void'(m_ha.pop_front());
          void'(m_hb.pop_front());
        end
        m_cnt++;
        if (m_cnt >= (1 << m_l)) m_run = 1;
      end
    end
    e.a = m_oa; e.b = m_ob; e.f = m_of;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input int ea, input int eb, input bit ef);
    n_checks++;
    if (OutputA !== 16'(ea) || OutputB !== 16'(eb) || Filled !== ef) begin
      n_errors++;
      $display("FAIL %s vec%0d: got A=%0d B=%0d Filled=%0b, want A=%0d B=%0d Filled=%0b",
               name, idx, OutputA, OutputB, Filled, 16'(ea), 16'(eb), ef);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   pa;
    int   pb;

    // Reset with L=2, constant 100: zero for 4 edges, then 100 and Filled.
    addc(1, 2, 100, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) addc(0, 2, 100, 0, 0, 0, 0);
    addc(0, 2, 100, 0, 100, 0, 1);
    addc(0, 2, 100, 0, 100, 0, 1);

    // L=1 alternating 1,2 (B mirrored): floor then round-half-up.
    add(0, 1, 1, -1);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) addc(0, 1, (i % 2) ? 2 : 1, (i % 2) ? -2 : -1, 1, -2, 1);
      else        add (0, 1, (i % 2) ? 2 : 1, (i % 2) ? -2 : -1);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) addc(0, 17, (i % 2) ? 2 : 1, (i % 2) ? -2 : -1, 2, -1, 1);
      else        add (0, 17, (i % 2) ? 2 : 1, (i % 2) ? -2 : -1);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) addc(0, 1, -3, 3, -3, 3, 1);
      else        add (0, 1, -3, 3);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 5) addc(0, 1, (i % 2) ? -1 : -2, (i % 2) ? 1 : 2, -2, 1, 1);
      else        add (0, 1, (i % 2) ? -1 : -2, (i % 2) ? 1 : 2);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) addc(0, 17, (i % 2) ? -1 : -2, (i % 2) ? 1 : 2, -1, 2, 1);
      else        add (0, 17, (i % 2) ? -1 : -2, (i % 2) ? 1 : 2);
    end

    // L=3: fill with zeros, then step to 800 and ramp in steps of 100.
    add(0, 3, 0, -50);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) addc(0, 3, 0, -50, 0, 0, 0);
      else        add (0, 3, 0, -50);
    end
    addc(0, 3, 800, -50, 0, -50, 1);
    for (int k = 1; k <= 8; k++) addc(0, 3, 800, -50, 100 * k, -50, 1);

    // Ramp down, hold 20 cycles with junk inputs, resume where it left off.
    addc(0, 3, 0, -50, 800, -50, 1);
    addc(0, 3, 0, -50, 700, -50, 1);
    addc(0, 3, 0, -50, 600, -50, 1);
    for (int i = 0; i < 20; i++) addc(0, 35, 12345, 777, 600, -50, 1);
    for (int k = 0; k < 6; k++) addc(0, 3, 0, -50, 500 - 100 * k, -50, 1);

    // L change while held: still flushes, outputs frozen until hold drops.
    for (int i = 0; i < 4; i++) addc(0, 34, 999, 999, 0, -50, 1);
    for (int i = 0; i < 4; i++) addc(0, 2, 40, -8, 0, 0, 0);
    addc(0, 2, 40, -8, 40, -8, 1);

    // L 2 -> 4: Filled drops one edge after the flush, refill of 16 samples.
    addc(0, 4, 160, 16, 40, -8, 1);
    for (int i = 0; i < 16; i++) addc(0, 4, 160, 16, 0, 0, 0);
    addc(0, 4, 160, 16, 160, 16, 1);
    addc(0, 4, 160, 16, 160, 16, 1);

    // Request 15 clamps to L=10: 1024-sample fill.
    addc(0, 15, 1000, -1000, 160, 16, 1);
    for (int i = 0; i < 1024; i++) begin
      if (i == 0 || i == 1023) addc(0, 15, 1000, -1000, 0, 0, 0);
      else                     add (0, 15, 1000, -1000);
    end
    addc(0, 15, 1000, -1000, 1000, -1000, 1);
    addc(0, 31, 1000, -1000, 1000, -1000, 1);

    // Reset from RUN, then reset mid-fill: a complete refill is required.
    addc(1, 2, 5, 6, 0, 0, 0);
    add(0, 2, 5, 6);
    add(0, 2, 5, 6);
    addc(1, 2, 5, 6, 0, 0, 0);
    for (int i = 0; i < 4; i++) addc(0, 2, 5, 6, 0, 0, 0);
    addc(0, 2, 5, 6, 5, 6, 1);

    // L=0: output is the input two registers later; round has no effect.
    add(0, 0, 0, 0);
    pa = 0; pb = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) addc(0, 0, i * 37 - 100, -i, 0, 0, 0);
      else        addc(0, (i % 2) ? 16 : 0, i * 37 - 100, -i, pa, pb, 1);
      pa = i * 37 - 100;
      pb = -i;
    end

    Control1 = 16'hA5A5;
    for (int i = 0; i < vecs.size(); i++) begin
      Reset    = vecs[i].rst;
      Control0 = vecs[i].ctrl;
      InputA   = 16'(vecs[i].a);
      InputB   = 16'(vecs[i].b);
      model_step(vecs[i].rst, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      @(posedge Clk);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard vec%0d: got empty queue, want one entry", i);
      end else begin
        e = exp_q.pop_front();
        check("model", i, e.a, e.b, e.f);
      end
      if (vecs[i].chk) check("table", i, vecs[i].ea, vecs[i].eb, vecs[i].ef);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
